// File: rtl/line_word_buffer.sv
// line_word_buffer: single-line staging buffer between the L1 datapath and a
// burst memory port. Assembles a line from fill beats, serves word reads as
// soon as the beat holding the word has landed (early restart), merges
// byte-masked word writes and drains the line back out in beats for writeback.
//
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_fill_start                   begin a new line fill (pulse, IDLE only)
//   i_fill_beat_valid/_data        incoming beat, beat 0 = line bits [BEAT_WIDTH-1:0]
//   o_fill_beat_ready              buffer accepts a beat (high throughout FILL)
//   i_wb_start                     begin writeback drain (pulse, needs a valid line)
//   o_wb_beat_valid/_data          outgoing beat, held stable until accepted
//   i_wb_beat_ready                memory accepts the current beat
//   i_rd_req/_offset               word read; o_rd_data/o_rd_valid one cycle later
//   i_wr_req/_offset/_data/_be     byte-masked word write; o_wr_ack one cycle later
//   o_line_valid                   every beat of the line is present
//   o_line_dirty                   line modified since fill
//   o_busy                         FILL or WB in progress
module line_word_buffer #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned WORDS      = 8,
  parameter int unsigned BEAT_WIDTH = 64,
  localparam int unsigned LINE_WIDTH   = WORD_WIDTH * WORDS,
  localparam int unsigned BEATS        = LINE_WIDTH / BEAT_WIDTH,
  localparam int unsigned OFFSET_WIDTH = $clog2(WORDS),
  localparam int unsigned BE_WIDTH     = WORD_WIDTH / 8,
  localparam int unsigned WPB          = BEAT_WIDTH / WORD_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_fill_start,
  input  logic                    i_fill_beat_valid,
  input  logic [BEAT_WIDTH-1:0]   i_fill_beat_data,
  output logic                    o_fill_beat_ready,
  input  logic                    i_wb_start,
  output logic                    o_wb_beat_valid,
  output logic [BEAT_WIDTH-1:0]   o_wb_beat_data,
  input  logic                    i_wb_beat_ready,
  input  logic                    i_rd_req,
  input  logic [OFFSET_WIDTH-1:0] i_rd_offset,
  output logic [WORD_WIDTH-1:0]   o_rd_data,
  output logic                    o_rd_valid,
  input  logic                    i_wr_req,
  input  logic [OFFSET_WIDTH-1:0] i_wr_offset,
  input  logic [WORD_WIDTH-1:0]   i_wr_data,
  input  logic [BE_WIDTH-1:0]     i_wr_be,
  output logic                    o_wr_ack,
  output logic                    o_line_valid,
  output logic                    o_line_dirty,
  output logic                    o_busy
);

  // A 1-bit counter is kept even for a single-beat line; it simply stays at 0.
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {StIdle, StFill, StWb} state_e;

  state_e                          r_state;
  logic [CNT_W-1:0]                r_fill_cnt;
  logic [CNT_W-1:0]                r_wb_cnt;
  logic [BEATS-1:0]                r_beat_present;
  logic                            r_line_valid;
  logic                            r_line_dirty;
  logic                            r_rd_valid;
  logic [WORD_WIDTH-1:0]           r_rd_data;
  logic                            r_wr_ack;
  logic                            r_wb_valid;
  logic                            r_fill_ready;

  logic [WORDS-1:0][WORD_WIDTH-1:0] w_words;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] w_beats;
  logic                             w_fill_fire;
  logic                             w_fill_last;
  logic                             w_wb_fire;
  logic                             w_wb_last;
  logic                             w_wr_fire;
  logic                             w_rd_hit;
  logic [CNT_W-1:0]                 w_rd_beat;

  assign w_fill_fire = r_fill_ready & i_fill_beat_valid;
  assign w_fill_last = (r_fill_cnt == CNT_W'(BEATS - 1));
  assign w_wb_fire   = r_wb_valid & i_wb_beat_ready;
  assign w_wb_last   = (r_wb_cnt == CNT_W'(BEATS - 1));
  assign w_wr_fire   = i_wr_req & (r_state == StIdle) & r_line_valid;
  assign w_rd_beat   = CNT_W'(32'(i_rd_offset) / WPB);
  // Presence mask is the registered value, so a beat landing on this edge
  // only becomes readable next cycle.
  assign w_rd_hit    = i_rd_req & r_beat_present[w_rd_beat];

  // Line storage, one byte lane at a time. Fill and write never coincide:
  // fills only happen in FILL, writes only in IDLE.
  for (genvar w = 0; w < WORDS; w++) begin : g_word
    for (genvar b = 0; b < BE_WIDTH; b++) begin : g_byte
      logic [7:0] r_byte;
      always_ff @(posedge i_clk) begin
        if (w_fill_fire && (r_fill_cnt == CNT_W'(w / WPB))) begin
          r_byte <= i_fill_beat_data[(w % WPB) * WORD_WIDTH + b * 8 +: 8];
        end else if (w_wr_fire && i_wr_be[b] && (i_wr_offset == OFFSET_WIDTH'(w))) begin
          r_byte <= i_wr_data[b * 8 +: 8];
        end
      end
      assign w_words[w][b * 8 +: 8] = r_byte;
    end
  end

  assign w_beats = w_words;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= StIdle;
      r_fill_cnt     <= '0;
      r_wb_cnt       <= '0;
      r_beat_present <= '0;
      r_line_valid   <= 1'b0;
      r_line_dirty   <= 1'b0;
      r_rd_valid     <= 1'b0;
      r_rd_data      <= '0;
      r_wr_ack       <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_fill_ready   <= 1'b0;
    end else begin
      // Read samples storage before any write on this edge: read-before-write.
      r_rd_valid <= w_rd_hit;
      if (w_rd_hit) begin
        r_rd_data <= w_words[i_rd_offset];
      end

      r_wr_ack <= w_wr_fire;
      if (w_wr_fire && (|i_wr_be)) begin
        r_line_dirty <= 1'b1;
      end

      unique case (r_state)
        StIdle: begin
          if (i_wb_start && r_line_valid) begin
            r_state    <= StWb;
            r_wb_cnt   <= '0;
            r_wb_valid <= 1'b1;
          end else if (i_fill_start) begin
            r_state        <= StFill;
            r_fill_cnt     <= '0;
            r_beat_present <= '0;
            r_line_valid   <= 1'b0;
            r_line_dirty   <= 1'b0;
            r_fill_ready   <= 1'b1;
          end
        end
        StFill: begin
          if (w_fill_fire) begin
            r_beat_present[r_fill_cnt] <= 1'b1;
            r_fill_cnt <= w_fill_last ? '0 : r_fill_cnt + 1'b1;
            if (w_fill_last) begin
              r_line_valid <= 1'b1;
              r_fill_ready <= 1'b0;
              r_state      <= StIdle;
            end
          end
        end
        StWb: begin
          if (w_wb_fire) begin
            r_wb_cnt <= w_wb_last ? '0 : r_wb_cnt + 1'b1;
            if (w_wb_last) begin
              r_line_dirty <= 1'b0;
              r_wb_valid   <= 1'b0;
              r_state      <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Storage is frozen during WB, so the selected beat holds under backpressure.
  assign o_wb_beat_data    = w_beats[r_wb_cnt];
  assign o_wb_beat_valid   = r_wb_valid;
  assign o_fill_beat_ready = r_fill_ready;
  assign o_rd_data         = r_rd_data;
  assign o_rd_valid        = r_rd_valid;
  assign o_wr_ack          = r_wr_ack;
  assign o_line_valid      = r_line_valid;
  assign o_line_dirty      = r_line_dirty;
  assign o_busy            = (r_state != StIdle);

endmodule

// File: tb/tb_line_word_buffer.sv
module tb_line_word_buffer;

  localparam int NW  = 8;
  localparam int NB  = 2;
  localparam int WPB = 4;

  int n_checks = 0;
  int n_errors = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance (16/8/64)
  logic        fill_start = 0, fill_valid = 0, fill_ready;
  logic [63:0] fill_data = '0, wb_data;
  logic        wb_start = 0, wb_valid, wb_ready = 0;
  logic        rd_req = 0, rd_valid, wr_req = 0, wr_ack;
  logic [2:0]  rd_offset = '0, wr_offset = '0;
  logic [15:0] rd_data, wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic        line_valid, line_dirty, busy;

  line_word_buffer u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fill_start(fill_start), .i_fill_beat_valid(fill_valid),
    .i_fill_beat_data(fill_data), .o_fill_beat_ready(fill_ready),
    .i_wb_start(wb_start), .o_wb_beat_valid(wb_valid), .o_wb_beat_data(wb_data),
    .i_wb_beat_ready(wb_ready),
    .i_rd_req(rd_req), .i_rd_offset(rd_offset), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .i_wr_req(wr_req), .i_wr_offset(wr_offset), .i_wr_data(wr_data), .i_wr_be(wr_be),
    .o_wr_ack(wr_ack), .o_line_valid(line_valid), .o_line_dirty(line_dirty), .o_busy(busy)
  );

  // Wide single-beat instance (32/4/128)
  logic         x_fill_start = 0, x_fill_valid = 0, x_fill_ready;
  logic [127:0] x_fill_data = '0, x_wb_data;
  logic         x_wb_start = 0, x_wb_valid, x_wb_ready = 0;
  logic         x_rd_req = 0, x_rd_valid, x_wr_req = 0, x_wr_ack;
  logic [1:0]   x_rd_offset = '0, x_wr_offset = '0;
  logic [31:0]  x_rd_data, x_wr_data = '0;
  logic [3:0]   x_wr_be = '0;
  logic         x_line_valid, x_line_dirty, x_busy;

  line_word_buffer #(.WORD_WIDTH(32), .WORDS(4), .BEAT_WIDTH(128)) u_dut_wide (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fill_start(x_fill_start), .i_fill_beat_valid(x_fill_valid),
    .i_fill_beat_data(x_fill_data), .o_fill_beat_ready(x_fill_ready),
    .i_wb_start(x_wb_start), .o_wb_beat_valid(x_wb_valid), .o_wb_beat_data(x_wb_data),
    .i_wb_beat_ready(x_wb_ready),
    .i_rd_req(x_rd_req), .i_rd_offset(x_rd_offset), .o_rd_data(x_rd_data),
    .o_rd_valid(x_rd_valid),
    .i_wr_req(x_wr_req), .i_wr_offset(x_wr_offset), .i_wr_data(x_wr_data),
    .i_wr_be(x_wr_be), .o_wr_ack(x_wr_ack), .o_line_valid(x_line_valid),
    .o_line_dirty(x_line_dirty), .o_busy(x_busy)
  );

  // Reference model: the line as a word array plus per-beat arrival flags.
  logic [15:0]   m_word [NW];
  logic [NB-1:0] m_present;
  logic          m_valid, m_dirty, m_busy;
  int            m_fill_cnt;
  logic [15:0]   m_rd;

  function automatic logic [127:0] m_line();
    logic [127:0] l;
    for (int i = 0; i < NW; i++) l[16*i +: 16] = m_word[i];
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_present = '0; m_valid = 0; m_dirty = 0; m_busy = 0; m_fill_cnt = 0; m_rd = '0;
  endtask

  task automatic do_fill_start();
    fill_start = 1; tick(); fill_start = 0;
    m_busy = 1; m_fill_cnt = 0; m_present = '0; m_valid = 0; m_dirty = 0;
  endtask

  task automatic do_beat(input logic [63:0] d, input int gap);
    repeat (gap) tick();
    fill_valid = 1; fill_data = d; tick(); fill_valid = 0;
    for (int j = 0; j < WPB; j++) m_word[m_fill_cnt*WPB + j] = d[16*j +: 16];
    m_present[m_fill_cnt] = 1'b1;
    m_fill_cnt++;
    if (m_fill_cnt == NB) begin m_valid = 1; m_busy = 0; end
  endtask

  task automatic do_read(input int off, output logic v, output logic [15:0] d,
                         output logic exp_v);
    exp_v = m_present[off / WPB];
    rd_req = 1; rd_offset = 3'(off); tick(); rd_req = 0;
    v = rd_valid; d = rd_data;
    if (exp_v) m_rd = m_word[off];
  endtask

  task automatic do_write(input int off, input logic [15:0] d, input logic [1:0] be,
                          output logic ack, output logic exp_ack);
    exp_ack = !m_busy && m_valid;
    wr_req = 1; wr_offset = 3'(off); wr_data = d; wr_be = be; tick(); wr_req = 0;
    ack = wr_ack;
    if (exp_ack) begin
      for (int b = 0; b < 2; b++) if (be[b]) m_word[off][8*b +: 8] = d[8*b +: 8];
      if (be != 2'b00) m_dirty = 1;
    end
  endtask

  // Drains the line; counts any cycle where the offered beat is not held.
  task automatic do_wb(input int stall0, output logic [127:0] got, output int bad);
    bad = 0;
    wb_start = 1; tick(); wb_start = 0;
    for (int k = 0; k < NB; k++) begin
      logic [63:0] first;
      int stalls;
      stalls = (k == 0) ? stall0 : int'($urandom_range(0, 2));
      first = wb_data;
      if (wb_valid !== 1'b1) bad++;
      repeat (stalls) begin
        tick();
        if (wb_data !== first || wb_valid !== 1'b1) bad++;
      end
      got[64*k +: 64] = first;
      wb_ready = 1; tick(); wb_ready = 0;
    end
    m_dirty = 0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks += 8;
    if (fill_ready !== 1'b0) begin n_errors++; $display("FAIL rst_fill_ready: got %b expected 0", fill_ready); end
    if (wb_valid !== 1'b0) begin n_errors++; $display("FAIL rst_wb_valid: got %b expected 0", wb_valid); end
    if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL rst_rd_valid: got %b expected 0", rd_valid); end
    if (rd_data !== 16'h0) begin n_errors++; $display("FAIL rst_rd_data: got %h expected 0000", rd_data); end
    if (wr_ack !== 1'b0) begin n_errors++; $display("FAIL rst_wr_ack: got %b expected 0", wr_ack); end
    if (line_valid !== 1'b0) begin n_errors++; $display("FAIL rst_line_valid: got %b expected 0", line_valid); end
    if (line_dirty !== 1'b0) begin n_errors++; $display("FAIL rst_line_dirty: got %b expected 0", line_dirty); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    rst_n = 1;
    model_reset();
    tick();
    n_checks++;
    if (x_line_valid !== 1'b0 || x_busy !== 1'b0) begin
      n_errors++; $display("FAIL rst_wide: got valid=%b busy=%b expected 0 0", x_line_valid, x_busy);
    end
  endtask

  task automatic test_fill_read();
    logic v, ev; logic [15:0] d;
    do_fill_start();
    n_checks++;
    if (fill_ready !== 1'b1 || busy !== 1'b1) begin
      n_errors++; $display("FAIL fill_enter: got ready=%b busy=%b expected 1 1", fill_ready, busy);
    end
    do_beat(64'h0003_0002_0001_0000, 0);
    n_checks++;
    if (line_valid !== 1'b0) begin n_errors++; $display("FAIL fill_half_valid: got %b expected 0", line_valid); end
    do_beat(64'h0007_0006_0005_0004, 0);
    n_checks++;
    if (line_valid !== 1'b1 || busy !== 1'b0 || fill_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL fill_done: got valid=%b busy=%b ready=%b expected 1 0 0", line_valid, busy, fill_ready);
    end
    do_read(5, v, d, ev);
    n_checks++;
    if (v !== 1'b1 || d !== 16'h0005) begin
      n_errors++; $display("FAIL fill_rd5: got v=%b d=%h expected v=1 d=0005", v, d);
    end
  endtask

  task automatic test_early_restart();
    logic v, ev; logic [15:0] d;
    do_fill_start();
    do_beat(64'h0003_0002_0001_0000, 0);
    do_read(2, v, d, ev);
    n_checks++;
    if (v !== 1'b1 || d !== 16'h0002) begin
      n_errors++; $display("FAIL er_rd2: got v=%b d=%h expected v=1 d=0002", v, d);
    end
    do_read(6, v, d, ev);
    n_checks++;
    if (v !== 1'b0 || d !== 16'h0002) begin
      n_errors++; $display("FAIL er_rd6_miss: got v=%b d=%h expected v=0 d=0002", v, d);
    end
    // Retry coincides with the edge that accepts beat 1: still a miss.
    rd_req = 1; rd_offset = 3'd6; fill_valid = 1; fill_data = 64'h0007_0006_0005_0004;
    tick();
    fill_valid = 0;
    for (int j = 0; j < WPB; j++) m_word[4 + j] = 16'(4 + j);
    m_present = 2'b11; m_valid = 1; m_busy = 0;
    n_checks++;
    if (rd_valid !== 1'b0 || line_valid !== 1'b1) begin
      n_errors++; $display("FAIL er_same_edge: got rdv=%b lv=%b expected 0 1", rd_valid, line_valid);
    end
    tick();
    rd_req = 0;
    m_rd = 16'h0006;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h0006) begin
      n_errors++; $display("FAIL er_retry: got v=%b d=%h expected v=1 d=0006", rd_valid, rd_data);
    end
  endtask

  task automatic test_byte_merge();
    logic v, ev, ack, eack; logic [15:0] d; logic [63:0] b0;
    do_write(3, 16'hABCD, 2'b10, ack, eack);
    n_checks++;
    if (ack !== 1'b1 || line_dirty !== 1'b1) begin
      n_errors++; $display("FAIL bm_ack: got ack=%b dirty=%b expected 1 1", ack, line_dirty);
    end
    do_read(3, v, d, ev);
    n_checks++;
    if (v !== 1'b1 || d !== 16'hAB03) begin
      n_errors++; $display("FAIL bm_rd3: got v=%b d=%h expected v=1 d=ab03", v, d);
    end
    b0 = {$urandom, $urandom};
    do_fill_start();
    do_beat(b0, 1);
    do_write(1, 16'h1234, 2'b11, ack, eack);
    n_checks++;
    if (ack !== 1'b0 || ack !== eack) begin
      n_errors++; $display("FAIL bm_fill_wr_ack: got %b expected 0", ack);
    end
    do_read(1, v, d, ev);
    n_checks++;
    if (v !== 1'b1 || d !== b0[31:16]) begin
      n_errors++; $display("FAIL bm_fill_rd1: got v=%b d=%h expected v=1 d=%h", v, d, b0[31:16]);
    end
    do_beat({$urandom, $urandom}, 0);
    n_checks++;
    if (line_dirty !== 1'b0) begin n_errors++; $display("FAIL bm_clean: got %b expected 0", line_dirty); end
  endtask

  task automatic test_writeback();
    logic v, ev, ack, eack; logic [15:0] d; logic [127:0] got; int bad;
    do_write(int'($urandom_range(0, 7)), 16'($urandom), 2'b11, ack, eack);
    n_checks++;
    if (ack !== 1'b1 || line_dirty !== 1'b1) begin
      n_errors++; $display("FAIL wb_pre_wr: got ack=%b dirty=%b expected 1 1", ack, line_dirty);
    end
    do_wb(3, got, bad);
    n_checks += 3;
    if (got !== m_line()) begin n_errors++; $display("FAIL wb_data: got %h expected %h", got, m_line()); end
    if (bad !== 0) begin n_errors++; $display("FAIL wb_stable: got %0d unstable cycles expected 0", bad); end
    if (line_dirty !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0 || line_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL wb_done: got dirty=%b busy=%b wbv=%b lv=%b expected 0 0 0 1",
               line_dirty, busy, wb_valid, line_valid);
    end
    // Empty byte mask: acknowledged, but the line stays clean.
    do_write(2, 16'($urandom), 2'b00, ack, eack);
    n_checks++;
    if (ack !== 1'b1 || line_dirty !== 1'b0) begin
      n_errors++; $display("FAIL wb_be0: got ack=%b dirty=%b expected 1 0", ack, line_dirty);
    end
    wb_start = 1; tick(); wb_start = 0;
    m_busy = 1;
    do_write(0, 16'hFFFF, 2'b11, ack, eack);
    n_checks++;
    if (ack !== 1'b0 || busy !== 1'b1) begin
      n_errors++; $display("FAIL wb_wr_reject: got ack=%b busy=%b expected 0 1", ack, busy);
    end
    wb_ready = 1; repeat (NB) tick(); wb_ready = 0;
    m_busy = 0;
    do_read(0, v, d, ev);
    n_checks++;
    if (v !== 1'b1 || d !== m_rd || busy !== 1'b0) begin
      n_errors++; $display("FAIL wb_rd0: got v=%b d=%h busy=%b expected 1 %h 0", v, d, busy, m_rd);
    end
  endtask

  task automatic test_priority_abort();
    logic v, ev, ack, eack; logic [15:0] d;
    wb_start = 1; fill_start = 1; tick(); wb_start = 0; fill_start = 0;
    n_checks++;
    if (wb_valid !== 1'b1 || fill_ready !== 1'b0 || line_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL pr_wb_wins: got wbv=%b fr=%b lv=%b expected 1 0 1", wb_valid, fill_ready, line_valid);
    end
    wb_ready = 1; repeat (NB) tick(); wb_ready = 0;
    m_dirty = 0;
    do_read(7, v, d, ev);
    n_checks++;
    if (v !== 1'b1 || d !== m_rd || busy !== 1'b0) begin
      n_errors++; $display("FAIL pr_rd7: got v=%b d=%h busy=%b expected 1 %h 0", v, d, busy, m_rd);
    end
    do_fill_start();
    do_beat({$urandom, $urandom}, 0);
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({line_valid, line_dirty, fill_ready, wb_valid, rd_valid, wr_ack, busy} !== 7'b0 ||
        rd_data !== 16'h0) begin
      n_errors++;
      $display("FAIL pr_abort: got lv=%b ld=%b fr=%b wbv=%b rdv=%b ack=%b busy=%b rd=%h expected all 0",
               line_valid, line_dirty, fill_ready, wb_valid, rd_valid, wr_ack, busy, rd_data);
    end
    tick();
    rst_n = 1;
    model_reset();
    do_read(0, v, d, ev);
    n_checks++;
    if (v !== 1'b0 || v !== ev || d !== 16'h0) begin
      n_errors++; $display("FAIL pr_rd_after_abort: got v=%b d=%h expected v=0 d=0000", v, d);
    end
    do_write(0, 16'h5A5A, 2'b11, ack, eack);
    n_checks++;
    if (ack !== 1'b0 || ack !== eack) begin n_errors++; $display("FAIL pr_wr_invalid: got %b expected 0", ack); end
    wb_start = 1; tick(); wb_start = 0;
    n_checks++;
    if (busy !== 1'b0 || wb_valid !== 1'b0) begin
      n_errors++; $display("FAIL pr_wb_invalid: got busy=%b wbv=%b expected 0 0", busy, wb_valid);
    end
  endtask

  task automatic test_random();
    logic v, ev, ack, eack; logic [15:0] d; logic [127:0] got; int bad; int off;
    for (int it = 0; it < 12; it++) begin
      do_fill_start();
      for (int k = 0; k < NB; k++) begin
        do_beat({$urandom, $urandom}, int'($urandom_range(0, 2)));
        off = int'($urandom_range(0, 7));
        do_read(off, v, d, ev);
        n_checks++;
        if (v !== ev || d !== m_rd) begin
          n_errors++; $display("FAIL rnd_fill_rd: it=%0d off=%0d got v=%b d=%h expected v=%b d=%h",
                               it, off, v, d, ev, m_rd);
        end
        if (k == 0) begin
          do_write(off, 16'($urandom), 2'b11, ack, eack);
          n_checks++;
          if (ack !== eack) begin n_errors++; $display("FAIL rnd_fill_wr: got %b expected %b", ack, eack); end
        end
      end
      for (int op = 0; op < 8; op++) begin
        off = int'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 0) begin
          do_read(off, v, d, ev);
          n_checks++;
          if (v !== ev || d !== m_rd) begin
            n_errors++; $display("FAIL rnd_rd: it=%0d off=%0d got v=%b d=%h expected v=%b d=%h",
                                 it, off, v, d, ev, m_rd);
          end
        end else begin
          do_write(off, 16'($urandom), 2'($urandom_range(0, 3)), ack, eack);
          n_checks++;
          if (ack !== eack || line_dirty !== m_dirty) begin
            n_errors++; $display("FAIL rnd_wr: it=%0d got ack=%b dirty=%b expected %b %b",
                                 it, ack, line_dirty, eack, m_dirty);
          end
        end
      end
      if (it % 2 == 1) begin
        do_wb(int'($urandom_range(0, 3)), got, bad);
        n_checks++;
        if (got !== m_line() || bad !== 0 || line_dirty !== 1'b0) begin
          n_errors++; $display("FAIL rnd_wb: it=%0d got %h bad=%0d dirty=%b expected %h 0 0",
                               it, got, bad, line_dirty, m_line());
        end
      end
    end
  endtask

  task automatic test_wide();
    logic [127:0] xl; logic [31:0] xd; logic [3:0] xbe;
    xl = {$urandom, $urandom, $urandom, $urandom};
    x_fill_start = 1; tick(); x_fill_start = 0;
    n_checks++;
    if (x_fill_ready !== 1'b1) begin n_errors++; $display("FAIL w_fill_ready: got %b expected 1", x_fill_ready); end
    x_fill_valid = 1; x_fill_data = xl; tick(); x_fill_valid = 0;
    n_checks++;
    if (x_line_valid !== 1'b1 || x_busy !== 1'b0) begin
      n_errors++; $display("FAIL w_fill_done: got lv=%b busy=%b expected 1 0", x_line_valid, x_busy);
    end
    x_rd_req = 1; x_rd_offset = 2'd3; tick(); x_rd_req = 0;
    n_checks++;
    if (x_rd_valid !== 1'b1 || x_rd_data !== xl[127:96]) begin
      n_errors++; $display("FAIL w_rd3: got v=%b d=%h expected v=1 d=%h", x_rd_valid, x_rd_data, xl[127:96]);
    end
    xd = $urandom; xbe = 4'b0101;
    x_wr_req = 1; x_wr_offset = 2'd1; x_wr_data = xd; x_wr_be = xbe; tick(); x_wr_req = 0;
    for (int b = 0; b < 4; b++) if (xbe[b]) xl[32 + 8*b +: 8] = xd[8*b +: 8];
    n_checks++;
    if (x_wr_ack !== 1'b1 || x_line_dirty !== 1'b1) begin
      n_errors++; $display("FAIL w_wr: got ack=%b dirty=%b expected 1 1", x_wr_ack, x_line_dirty);
    end
    x_rd_req = 1; x_rd_offset = 2'd1; tick(); x_rd_req = 0;
    n_checks++;
    if (x_rd_data !== xl[63:32]) begin n_errors++; $display("FAIL w_rd1: got %h expected %h", x_rd_data, xl[63:32]); end
    x_wb_start = 1; tick(); x_wb_start = 0;
    n_checks++;
    if (x_wb_valid !== 1'b1 || x_wb_data !== xl) begin
      n_errors++; $display("FAIL w_wb_beat: got v=%b d=%h expected v=1 d=%h", x_wb_valid, x_wb_data, xl);
    end
    x_wb_ready = 1; tick(); x_wb_ready = 0;
    n_checks++;
    if (x_wb_valid !== 1'b0 || x_busy !== 1'b0 || x_line_dirty !== 1'b0) begin
      n_errors++; $display("FAIL w_wb_done: got wbv=%b busy=%b dirty=%b expected 0 0 0",
                           x_wb_valid, x_busy, x_line_dirty);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_read();
    test_early_restart();
    test_byte_merge();
    test_writeback();
    test_priority_abort();
    test_random();
    test_wide();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
